// File: rtl/shift_pkg.sv
// Shared definitions for the shift execution unit: op encodings, op field
// positions and default datapath widths.
package shift_pkg;

    localparam int SHIFT_W     = 32;
    localparam int SHIFT_TAG_W = 7;

    localparam int OP_RIGHT_BIT = 0;
    localparam int OP_ARITH_BIT = 1;

    // 2'b10 is not a distinct op; the unit treats it as a left shift.
    localparam logic [1:0] SHOP_SLL = 2'b00;
    localparam logic [1:0] SHOP_SRL = 2'b01;
    localparam logic [1:0] SHOP_SRA = 2'b11;

endpackage

// File: rtl/shift_exec_shf.sv
// Combinational barrel shifter. Left shifts reuse the right-shift datapath
// by bit-reversing the operand before and the result after the shift.
module shf #(
    parameter int W     = 32,
    parameter bit RIGHT = 1'b1,
    localparam int SW   = $clog2(W)
) (
    input  logic [W-1:0]  a,
    input  logic [SW-1:0] b,
    input  logic          sgn,
    output logic [W-1:0]  y
);

    logic [W-1:0] src;
    logic [W-1:0] shifted;
    logic [W-1:0] fill_mask;
    logic         fill;

    // The sign fill is taken from the original MSB; a left instance has sgn tied low.
    always_comb begin
        src = '0;
        y   = '0;
        for (int i = 0; i < W; i++) begin
            src[i] = RIGHT ? a[i] : a[W-1-i];
        end
        fill      = sgn & a[W-1];
        fill_mask = ~({W{1'b1}} >> b);
        shifted   = (src >> b) | (fill ? fill_mask : '0);
        for (int i = 0; i < W; i++) begin
            y[i] = RIGHT ? shifted[i] : shifted[W-1-i];
        end
    end

endmodule

// File: rtl/shift_exec.sv
// Two-stage pipelined shift unit: S1 registers the issued operands, S2
// registers the shifted result and presents it to writeback over valid/ready.
module shift_exec
    import shift_pkg::*;
#(
    parameter int W     = SHIFT_W,
    parameter int TAG_W = SHIFT_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [TAG_W-1:0]     req_tag,
    input  logic [W-1:0]         req_a,
    input  logic [$clog2(W)-1:0] req_b,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [TAG_W-1:0]     result_tag,
    output logic [W-1:0]         result_value
);

    logic                 s1_valid;
    logic [1:0]           s1_op;
    logic [TAG_W-1:0]     s1_tag;
    logic [W-1:0]         s1_a;
    logic [$clog2(W)-1:0] s1_b;

    logic                 s2_valid;
    logic [TAG_W-1:0]     s2_tag;
    logic [W-1:0]         s2_value;

    logic                 s2_free;
    logic                 advance;
    logic                 accept;
    logic [W-1:0]         left_y;
    logic [W-1:0]         right_y;

    // req_ready is combinational from result_ready so a draining S2 frees a slot the same cycle.
    assign s2_free   = !s2_valid || result_ready;
    assign advance   = s1_valid && s2_free;
    assign req_ready = !flush && (!s1_valid || s2_free);
    assign accept    = req_valid && req_ready;

    shf #(.W(W), .RIGHT(1'b0)) lshf_u (
        .a   (s1_a),
        .b   (s1_b),
        .sgn (1'b0),
        .y   (left_y)
    );

    shf #(.W(W), .RIGHT(1'b1)) rshf_u (
        .a   (s1_a),
        .b   (s1_b),
        .sgn (s1_op[OP_ARITH_BIT]),
        .y   (right_y)
    );

    // S1 operand registers carry no reset; s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= req_op;
            s1_tag <= req_tag;
            s1_a   <= req_a;
            s1_b   <= req_b;
        end
    end

    // Reset beats flush, flush beats any accept/advance/drain in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_value <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                s2_valid <= 1'b1;
                s2_tag   <= s1_tag;
                s2_value <= s1_op[OP_RIGHT_BIT] ? right_y : left_y;
            end else if (s2_valid && result_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign result_valid = s2_valid;
    assign result_tag   = s2_tag;
    assign result_value = s2_value;

endmodule

// File: tb/tb_shift_exec.sv
// Scoreboard bench for shift_exec: expected results are queued as ops are
// accepted and popped by a monitor whenever a result handshake occurs.
module tb_shift_exec;
    import shift_pkg::*;

    typedef struct packed {
        logic [6:0]  tag;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [6:0]  req_tag;
    logic [31:0] req_a;
    logic [4:0]  req_b;
    logic        result_valid;
    logic        result_ready;
    logic [6:0]  result_tag;
    logic [31:0] result_value;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pop_count = 0;

    shift_exec #(.W(32), .TAG_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_tag      (req_tag),
        .req_a        (req_a),
        .req_b        (req_b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_tag   (result_tag),
        .result_value (result_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] b);
        if (op == SHOP_SRA) return 32'($signed(a) >>> b);
        if (op == SHOP_SRL) return a >> b;
        return a << b;
    endfunction

    // Result handshakes are checked against the scoreboard at the negedge.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            pop_count++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL unexpected_result: got tag=%0h value=%08h, required no result",
                         result_tag, result_value);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (result_tag !== e.tag || result_value !== e.value) begin
                    n_bad++;
                    $display("[TB] FAIL result: got tag=%0h value=%08h, required tag=%0h value=%08h",
                             result_tag, result_value, e.tag, e.value);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_op(input logic [1:0] op, input logic [6:0] tag, input logic [31:0] a,
                           input logic [4:0] b, input logic [31:0] exp, output int waited);
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_tag   = tag;
        req_a     = a;
        req_b     = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 20) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL accept_timeout: tag=%0h not accepted, required accept", tag);
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
        end
        e.tag   = tag;
        e.value = exp;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || result_tag !== 7'd0 || result_value !== 32'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got v=%b tag=%0h value=%08h, required 0/0/0",
                     result_valid, result_tag, result_value);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_req_ready: got %b, required 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [1:0]  ops  [5] = '{SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_SRA, SHOP_SLL};
        logic [31:0] as   [5] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'hDEADBEEF};
        logic [4:0]  bs   [5] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd0};
        logic [31:0] exps [5] = '{32'h80000000, 32'h08000000, 32'hF8000000, 32'h00000000, 32'hDEADBEEF};
        int waited;
        int base;
        result_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            base = pop_count;
            send_op(ops[i], 7'(8'h40 + i), as[i], bs[i], exps[i], waited);
            @(negedge clk); #1;
            n_cmp++;
            if (pop_count !== base) begin
                n_bad++;
                $display("[TB] FAIL basic_latency_early[%0d]: got %0d results, required 0", i, pop_count - base);
            end
            @(negedge clk); #1;
            n_cmp++;
            if (pop_count !== base + 1) begin
                n_bad++;
                $display("[TB] FAIL basic_latency[%0d]: got %0d results, required 1", i, pop_count - base);
            end
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int waited;
        int stalls = 0;
        int base;
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  b;
        result_ready = 1'b1;
        base = pop_count;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = 5'($urandom_range(0, 31));
            send_op(op, 7'(8'h10 + i), a, b, ref_shift(op, a, b), waited);
            stalls += waited;
        end
        n_cmp++;
        if (stalls != 0) begin
            n_bad++;
            $display("[TB] FAIL b2b_req_ready: got %0d stall cycles, required 0", stalls);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (pop_count - base != 7) begin
            n_bad++;
            $display("[TB] FAIL b2b_rate: got %0d results, required 7", pop_count - base);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (pop_count - base != 8) begin
            n_bad++;
            $display("[TB] FAIL b2b_rate_end: got %0d results, required 8", pop_count - base);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_backpressure();
        int waited;
        exp_t e;
        result_ready = 1'b0;
        send_op(SHOP_SRL, 7'h21, 32'hF0000000, 5'd8, 32'h00F00000, waited);
        send_op(SHOP_SRA, 7'h22, 32'h80000010, 5'd1, 32'hC0000008, waited);
        req_valid = 1'b1;
        req_op    = SHOP_SLL;
        req_tag   = 7'h23;
        req_a     = 32'h0000FFFF;
        req_b     = 5'd16;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL bp_req_ready[%0d]: got %b, required 0", i, req_ready);
            end
            n_cmp++;
            if (result_valid !== 1'b1 || result_tag !== 7'h21 || result_value !== 32'h00F00000) begin
                n_bad++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%b tag=%0h value=%08h, required 1/21/00f00000",
                         i, result_valid, result_tag, result_value);
            end
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL bp_release_ready: got %b, required 1", req_ready);
        end else begin
            e.tag   = 7'h23;
            e.value = 32'hFFFF0000;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        int waited;
        int base;
        result_ready = 1'b0;
        send_op(SHOP_SLL, 7'h31, 32'h00000011, 5'd2, 32'h00000044, waited);
        send_op(SHOP_SRL, 7'h32, 32'h00001000, 5'd4, 32'h00000100, waited);
        req_valid = 1'b1;
        req_op    = SHOP_SRA;
        req_tag   = 7'h33;
        req_a     = 32'h80000000;
        req_b     = 5'd1;
        flush     = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL flush_req_ready: got %b, required 0", req_ready);
        end
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL flush_clear: got valid=%b ready=%b, required 0/1", result_valid, req_ready);
        end
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        base = pop_count;
        send_op(SHOP_SRA, 7'h34, 32'h80000000, 5'd31, 32'hFFFFFFFF, waited);
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_cmp++;
        if (pop_count !== base + 1) begin
            n_bad++;
            $display("[TB] FAIL flush_after_op: got %0d results, required 1", pop_count - base);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_reset_midop();
        int waited;
        result_ready = 1'b0;
        send_op(SHOP_SLL, 7'h51, 32'h12345678, 5'd4, 32'h23456780, waited);
        send_op(SHOP_SRL, 7'h52, 32'h12345678, 5'd4, 32'h01234567, waited);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || result_tag !== 7'd0 || result_value !== 32'd0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL midop_reset: got v=%b tag=%0h value=%08h ready=%b, required 0/0/0/1",
                     result_valid, result_tag, result_value, req_ready);
        end
        result_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_op10();
        int waited;
        int base;
        result_ready = 1'b1;
        base = pop_count;
        send_op(2'b10, 7'h61, 32'h00000003, 5'd1, 32'h00000006, waited);
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_cmp++;
        if (pop_count !== base + 1) begin
            n_bad++;
            $display("[TB] FAIL op10_latency: got %0d results, required 1", pop_count - base);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_tag      = '0;
        req_a        = '0;
        req_b        = '0;
        result_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_op10();
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
